// File: rtl/lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_master
// Description : Load/store initiator for the CPU memory stage. Accepts one
//               request at a time, computes and checks the effective address,
//               issues a single word-port access and returns the (extended)
//               load result or a fault code to the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_master #(
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [31:0] req_base_i,
    input  logic [15:0] req_offset_i,
    input  logic [31:0] req_wdata_i,
    input  logic [31:0] req_pc_i,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [11:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_data_o,
    output logic        resp_exc_o,
    output logic [1:0]  resp_exc_code_o,
    output logic [31:0] resp_badaddr_o,
    output logic [31:0] resp_pc_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_FAULT   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [1:0] EXC_NONE  = 2'd0;
    localparam logic [1:0] EXC_ALIGN = 2'd1;
    localparam logic [1:0] EXC_RANGE = 2'd2;

    // Stores are the three encodings 5..7
    function automatic logic is_store(input logic [2:0] op);
        return op[2] & (op[1] | op[0]);
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic [31:0] ea_q;
    logic [31:0] pc_q;
    logic [1:0]  code_q;

    logic        mem_en_q, mem_we_q;
    logic [3:0]  mem_be_q;
    logic [11:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        resp_valid_q, resp_exc_q;
    logic [31:0] resp_data_q, resp_badaddr_q, resp_pc_q;
    logic [1:0]  resp_code_q;

    logic [31:0] ea;
    logic        is_word, is_half, misaligned, out_of_range, accept;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    // Decode the incoming request: effective address, fault code, lane encoding
    always_comb begin
        ea           = req_base_i + {{16{req_offset_i[15]}}, req_offset_i};
        is_word      = (req_op_i == OP_LW) || (req_op_i == OP_SW);
        is_half      = (req_op_i == OP_LH) || (req_op_i == OP_LHU) || (req_op_i == OP_SH);
        misaligned   = (is_word && (ea[1:0] != 2'b00)) || (is_half && ea[0]);
        out_of_range = (ea >= ADDR_LIMIT);
        code         = misaligned ? EXC_ALIGN : (out_of_range ? EXC_RANGE : EXC_NONE);
        be           = 4'b1111;
        wdata        = req_wdata_i;
        case (req_op_i)
            OP_SH: begin
                be    = ea[1] ? 4'b1100 : 4'b0011;
                wdata = {req_wdata_i[15:0], req_wdata_i[15:0]};
            end
            OP_SB: begin
                be    = 4'b0001 << ea[1:0];
                wdata = {4{req_wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed lane of the returned word
    always_comb begin
        rd_byte   = 8'(mem_rdata_i >> {ea_q[1:0], 3'b000});
        rd_half   = ea_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        load_data = mem_rdata_i;
        case (op_q)
            OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            OP_LHU:  load_data = {16'h0000, rd_half};
            OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            OP_LBU:  load_data = {24'h000000, rd_byte};
            default: load_data = mem_rdata_i;
        endcase
    end

    // Next-state logic and request handshake
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        accept      = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = (code != EXC_NONE) ? S_FAULT : S_ISSUE;
                end
            end
            S_ISSUE:   state_d = is_store(op_q) ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_FAULT:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the accepted request for the remaining states
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 3'd0;
            ea_q   <= 32'd0;
            pc_q   <= 32'd0;
            code_q <= EXC_NONE;
        end else if (accept) begin
            op_q   <= req_op_i;
            ea_q   <= ea;
            pc_q   <= req_pc_i;
            code_q <= code;
        end
    end

    // Registered memory-port and response outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_be_q       <= 4'd0;
            mem_addr_q     <= 12'd0;
            mem_wdata_q    <= 32'd0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= 32'd0;
            resp_exc_q     <= 1'b0;
            resp_code_q    <= EXC_NONE;
            resp_badaddr_q <= 32'd0;
            resp_pc_q      <= 32'd0;
        end else begin
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            // The strobe is launched at acceptance so it appears in the ISSUE cycle
            if (accept && (code == EXC_NONE)) begin
                mem_en_q   <= 1'b1;
                mem_we_q   <= is_store(req_op_i);
                mem_be_q   <= be;
                mem_addr_q <= ea[13:2];
                if (is_store(req_op_i)) begin
                    mem_wdata_q <= wdata;
                end
            end
            if ((state_q == S_ISSUE) && is_store(op_q)) begin
                resp_valid_q   <= 1'b1;
                resp_data_q    <= 32'd0;
                resp_exc_q     <= 1'b0;
                resp_code_q    <= EXC_NONE;
                resp_badaddr_q <= 32'd0;
                resp_pc_q      <= pc_q;
            end
            if (state_q == S_CAPTURE) begin
                resp_valid_q   <= 1'b1;
                resp_data_q    <= load_data;
                resp_exc_q     <= 1'b0;
                resp_code_q    <= EXC_NONE;
                resp_badaddr_q <= 32'd0;
                resp_pc_q      <= pc_q;
            end
            if (state_q == S_FAULT) begin
                resp_valid_q   <= 1'b1;
                resp_data_q    <= 32'd0;
                resp_exc_q     <= 1'b1;
                resp_code_q    <= code_q;
                resp_badaddr_q <= ea_q;
                resp_pc_q      <= pc_q;
            end
        end
    end

    assign mem_en_o        = mem_en_q;
    assign mem_we_o        = mem_we_q;
    assign mem_be_o        = mem_be_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign resp_valid_o    = resp_valid_q;
    assign resp_data_o     = resp_data_q;
    assign resp_exc_o      = resp_exc_q;
    assign resp_exc_code_o = resp_code_q;
    assign resp_badaddr_o  = resp_badaddr_q;
    assign resp_pc_o       = resp_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_master
// Description : Self-checking bench for lsu_master: directed cases with
//               literal expectations plus randomized traffic against a
//               cycle-level behavioural model and a backing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_base = 32'd0;
    logic [15:0] req_offset = 16'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [31:0] req_pc = 32'd0;
    logic        mem_en, mem_we;
    logic [3:0]  mem_be;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        resp_valid, resp_exc;
    logic [31:0] resp_data, resp_badaddr, resp_pc;
    logic [1:0]  resp_exc_code;

    lsu_master dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
        .req_base_i(req_base), .req_offset_i(req_offset), .req_wdata_i(req_wdata),
        .req_pc_i(req_pc),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .resp_valid_o(resp_valid), .resp_data_o(resp_data), .resp_exc_o(resp_exc),
        .resp_exc_code_o(resp_exc_code), .resp_badaddr_o(resp_badaddr), .resp_pc_o(resp_pc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        else n_pass++;
    endtask

    // ---------------- backing memory (driven by the DUT port) --------------
    logic [31:0] envmem [4096];
    logic [31:0] modmem [4096];
    bit          rd_pend = 1'b0;
    logic [11:0] rd_addr = 12'd0;

    initial begin
        forever begin
            @(negedge clk);
            mem_rdata = rd_pend ? envmem[rd_addr] : $urandom;
            rd_pend   = mem_en && !mem_we;
            rd_addr   = mem_addr;
            if (mem_en && mem_we)
                for (int k = 0; k < 4; k++)
                    if (mem_be[k]) envmem[mem_addr][8*k +: 8] = mem_wdata[8*k +: 8];
        end
    end

    // ---------------- behavioural model ------------------------------------
    // Cycle n is the interval following rising edge n.
    int          cyc = 0;
    bit          model_on = 1'b0;
    int          free_at = 0;
    int          exp_mem_at = -1;
    int          exp_resp_at = -1;
    bit          exp_we = 1'b0;
    logic [3:0]  last_be = 4'd0;
    logic [11:0] last_addr = 12'd0;
    logic [31:0] exp_wdata = 32'd0;
    logic [31:0] e_data = 32'd0, e_bad = 32'd0, e_pc = 32'd0;
    logic        e_exc = 1'b0;
    logic [1:0]  e_code = 2'd0;

    initial begin
        logic [31:0] ea, w;
        int          size, lane;
        bit          store;
        logic [1:0]  code;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                model_on = 1'b1; free_at = cyc + 1; exp_mem_at = -1; exp_resp_at = -1;
                last_be = 4'd0; last_addr = 12'd0;
            end else if (model_on && cyc >= free_at && req_valid) begin
                ea    = req_base + 32'(int'($signed(req_offset)));
                size  = (req_op == 3'd0 || req_op == 3'd5) ? 4 :
                        (req_op == 3'd1 || req_op == 3'd2 || req_op == 3'd6) ? 2 : 1;
                store = (req_op >= 3'd5);
                code  = ((ea & 32'(size - 1)) != 0) ? 2'd1 : (ea >= 32'h3000) ? 2'd2 : 2'd0;
                e_pc  = req_pc;
                e_data = 32'd0; e_exc = 1'b0; e_code = 2'd0; e_bad = 32'd0;
                if (code != 2'd0) begin
                    exp_resp_at = cyc + 1; free_at = cyc + 3;
                    e_exc = 1'b1; e_code = code; e_bad = ea;
                end else begin
                    exp_mem_at = cyc; exp_we = store; last_addr = ea[13:2];
                    if (store) begin
                        last_be = 4'd0;
                        for (int k = 0; k < size; k++) begin
                            lane = int'(ea[1:0]) + k;
                            last_be[lane] = 1'b1;
                            modmem[ea[13:2]][8*lane +: 8] = req_wdata[8*k +: 8];
                        end
                        exp_wdata = (size == 4) ? req_wdata :
                                    (size == 2) ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
                        exp_resp_at = cyc + 1; free_at = cyc + 3;
                    end else begin
                        last_be = 4'hF;
                        w = modmem[ea[13:2]] >> (8 * int'(ea[1:0]));
                        if (size == 4)      e_data = w;
                        else if (size == 2) e_data = (req_op == 3'd1 && w[15]) ? (w | 32'hFFFF0000) : (w & 32'h0000FFFF);
                        else                e_data = (req_op == 3'd3 && w[7])  ? (w | 32'hFFFFFF00) : (w & 32'h000000FF);
                        exp_resp_at = cyc + 2; free_at = cyc + 4;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    initial begin
        bit en_exp, rv_exp;
        forever begin
            @(negedge clk);
            if (model_on) begin
                en_exp = (cyc == exp_mem_at);
                rv_exp = (cyc == exp_resp_at);
                chk("req_ready", 32'(req_ready), 32'(cyc + 1 >= free_at));
                chk("mem_en", 32'(mem_en), 32'(en_exp));
                chk("mem_we", 32'(mem_we), 32'(en_exp && exp_we));
                chk("mem_be", 32'(mem_be), 32'(last_be));
                chk("mem_addr", 32'(mem_addr), 32'(last_addr));
                if (en_exp && exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
                chk("resp_valid", 32'(resp_valid), 32'(rv_exp));
                if (rv_exp) begin
                    chk("resp_data", resp_data, e_data);
                    chk("resp_exc", 32'(resp_exc), 32'(e_exc));
                    chk("resp_code", 32'(resp_exc_code), 32'(e_code));
                    chk("resp_badaddr", resp_badaddr, e_bad);
                    chk("resp_pc", resp_pc, e_pc);
                end
            end
        end
    end

    // ---------------- directed helpers -------------------------------------
    int          c_en_k, c_resp_k, c_en_n;
    logic        c_we, c_exc;
    logic [3:0]  c_be;
    logic [11:0] c_addr;
    logic [31:0] c_wdata, c_data, c_bad;
    logic [1:0]  c_code;

    task automatic wait_ready();
        int guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        if (!req_ready) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] base,
                         input logic [15:0] off, input logic [31:0] wd);
        wait_ready();
        req_op = op; req_base = base; req_offset = off; req_wdata = wd;
        req_pc = $urandom; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        c_en_k = -1; c_resp_k = -1; c_en_n = 0;
        for (int k = 0; k < 8 && c_resp_k < 0; k++) begin
            if (mem_en) begin
                c_en_n++;
                if (c_en_k < 0) c_en_k = k;
                c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wdata = mem_wdata;
            end
            if (resp_valid) begin
                c_resp_k = k; c_data = resp_data; c_exc = resp_exc;
                c_code = resp_exc_code; c_bad = resp_badaddr;
            end
            if (c_resp_k < 0) @(negedge clk);
        end
        if (c_resp_k < 0) chk("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    // ---------------- main stimulus ----------------------------------------
    initial begin
        int st0, st1, n_en, n_rs, p;
        logic [31:0] v;
        for (int i = 0; i < 4096; i++) begin v = $urandom; envmem[i] = v; modmem[i] = v; end
        envmem[12'h040] = 32'd0; modmem[12'h040] = 32'd0;

        repeat (3) @(negedge clk);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_pc", resp_pc, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);

        do_op(3'd5, 32'h100, 16'h0008, 32'hDEADBEEF);
        chk("sw_en_lat", 32'(c_en_k), 32'd0);
        chk("sw_we", 32'(c_we), 32'd1);
        chk("sw_addr", 32'(c_addr), 32'h042);
        chk("sw_be", 32'(c_be), 32'hF);
        chk("sw_wdata", c_wdata, 32'hDEADBEEF);
        chk("sw_resp_lat", 32'(c_resp_k), 32'd1);
        chk("sw_exc", 32'(c_exc), 32'd0);

        do_op(3'd7, 32'h100, 16'h0003, 32'h000000A5);
        chk("sb_be", 32'(c_be), 32'h8);
        chk("sb_wdata", c_wdata, 32'hA5A5A5A5);
        do_op(3'd3, 32'h100, 16'h0003, 32'd0);
        chk("lb_resp_lat", 32'(c_resp_k), 32'd2);
        chk("lb_data", c_data, 32'hFFFFFFA5);
        do_op(3'd4, 32'h100, 16'h0003, 32'd0);
        chk("lbu_data", c_data, 32'h000000A5);

        do_op(3'd6, 32'h100, 16'h0002, 32'h12348001);
        chk("sh_be", 32'(c_be), 32'hC);
        chk("sh_wdata", c_wdata, 32'h80018001);
        do_op(3'd1, 32'h100, 16'h0002, 32'd0);
        chk("lh_data", c_data, 32'hFFFF8001);
        do_op(3'd2, 32'h100, 16'h0002, 32'd0);
        chk("lhu_data", c_data, 32'h00008001);

        do_op(3'd0, 32'h100, 16'h0006, 32'd0);
        chk("lw_mis_en", 32'(c_en_n), 32'd0);
        chk("lw_mis_lat", 32'(c_resp_k), 32'd1);
        chk("lw_mis_code", 32'(c_code), 32'd1);
        chk("lw_mis_bad", c_bad, 32'h106);
        do_op(3'd5, 32'h3000, 16'h0000, 32'h1);
        chk("sw_oor_code", 32'(c_code), 32'd2);
        chk("sw_oor_en", 32'(c_en_n), 32'd0);
        do_op(3'd1, 32'h3000, 16'h0001, 32'd0);
        chk("lh_both_code", 32'(c_code), 32'd1);

        do_op(3'd0, 32'hFFFFFFFC, 16'h0008, 32'd0);
        chk("wrap_exc", 32'(c_exc), 32'd0);
        chk("wrap_addr", 32'(c_addr), 32'h001);
        do_op(3'd0, 32'h200, 16'hFFFC, 32'd0);
        chk("negoff_addr", 32'(c_addr), 32'h07F);

        // Back-to-back with req_valid held high, then pulses while busy
        wait_ready();
        req_op = 3'd5; req_base = 32'h200; req_offset = 16'd0; req_wdata = 32'h11112222;
        req_pc = 32'h400; req_valid = 1'b1;
        @(negedge clk);
        req_op = 3'd0; req_pc = 32'h404;
        st0 = -1; st1 = -1; n_en = 0; n_rs = 0; p = 0;
        for (int k = 0; k < 10; k++) begin
            if (mem_en) begin n_en++; if (st0 < 0) st0 = k; else if (st1 < 0) st1 = k; end
            if (resp_valid) n_rs++;
            if (p > 0) p++;
            if (p == 0 && req_ready) p = 1;
            if (p == 2) begin req_op = 3'd7; req_valid = 1'b1; end
            else if (p == 3) req_valid = 1'b0;
            else if (p == 4) req_valid = 1'b1;
            else if (p >= 5) req_valid = 1'b0;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("b2b_strobes", 32'(n_en), 32'd2);
        chk("b2b_first", 32'(st0), 32'd0);
        chk("b2b_second", 32'(st1), 32'd3);
        chk("b2b_resps", 32'(n_rs), 32'd2);

        // Reset during the CAPTURE cycle of a load
        wait_ready();
        req_op = 3'd0; req_base = 32'h300; req_offset = 16'd0; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_addr", 32'(mem_addr), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_resp_data", resp_data, 32'd0);
        n_rs = 0;
        for (int k = 0; k < 5; k++) begin @(negedge clk); if (resp_valid) n_rs++; end
        chk("abort_no_resp", 32'(n_rs), 32'd0);
        do_op(3'd0, 32'h100, 16'h0008, 32'd0);
        chk("post_abort_lw", c_data, 32'hDEADBEEF);
        chk("post_abort_lat", 32'(c_resp_k), 32'd2);

        // Randomized traffic; the model decides acceptance every cycle
        for (int i = 0; i < 3000; i++) begin
            req_valid = ($urandom % 4) != 0;
            req_op    = 3'($urandom);
            case ($urandom % 8)
                0:       req_base = $urandom;
                1:       req_base = 32'hFFFFFF00 | ($urandom % 256);
                default: req_base = $urandom_range(0, 32'h3100);
            endcase
            req_offset = (($urandom % 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) - 128);
            req_wdata  = $urandom;
            req_pc     = $urandom;
            @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (6) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_master.md
# lsu_master

Load/store initiator that sits in the CPU memory stage and drives the word-organised data-memory port. Accepts one load/store request at a time and computes the effective address. Checks alignment and range, then issues a single memory access with byte enables and lane-replicated write data. For loads, it extracts, zero-extends or sign-extends the returned lane and reports the result or a fault back to the pipeline.

## Interface
- ADDR_LIMIT, 32'h0000_3000, byte size of the data region; any effective address >= ADDR_LIMIT (unsigned) faults.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
- req_op  in  3  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 SW, 6 SH, 7 SB.
- req_base  in  32  base register value.
- req_offset  in  16  signed immediate.
- req_wdata  in  32  store source register.
- req_pc  in  32  PC of the instruction, returned with the response.
- mem_en  out  1  one-cycle access strobe (registered).
- mem_we  out  1  write qualifier, valid with mem_en.
- mem_be  out  4  byte enables, bit k = byte lane [8k+7:8k].
- mem_addr  out  12  word index = effective address [13:2].
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word; valid exactly one cycle after a read strobe.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  load result; 0 for stores and faults.
- resp_exc  out  1  access faulted; no memory access was made.
- resp_exc_code  out  2  0 none, 1 misaligned, 2 out of range.
- resp_badaddr  out  32  faulting effective address, else 0.
- resp_pc  out  32  req_pc of the request being answered.

## Operation
- Effective address EA = req_base + sign_extend(req_offset), modulo 2^32, computed at acceptance and latched with op, wdata, pc.
- Fault checks at acceptance:
  - Misaligned: word op with EA[1:0] != 0, or half op with EA[0] != 0.
  - Out of range: EA >= ADDR_LIMIT.
  - Misaligned takes priority when both apply.
- States:
  - IDLE: req_ready=1. On acceptance, go to FAULT if faulting, else ISSUE.
  - ISSUE: mem_en=1; mem_we=1 for stores. Stores go to RESP; loads go to CAPTURE.
  - CAPTURE: sample mem_rdata, extract the addressed lane, go to RESP.
  - FAULT: no mem_en; latch the code and EA into the response registers, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, then go to IDLE.
- Lanes are little-endian; byte k of a word is bits [8k+7:8k].
  - Half at EA[1]=0 is bits [15:0]; at EA[1]=1 it is bits [31:16].
- Store encoding:
  - SW: be=1111, wdata=req_wdata.
  - SH: be=0011 or 1100, wdata={wdata[15:0],wdata[15:0]}.
  - SB: be=one-hot(EA[1:0]), wdata=wdata[7:0] replicated x4.
- Load encoding:
  - mem_be is 1111 for all loads.
  - LH/LB sign-extend the lane; LHU/LBU zero-extend; LW passes the word.
- req_ready=0 in every state except IDLE; at most one request is in flight.

## Timing
- Reset values: state IDLE, mem_en/mem_we 0, mem_be 0, mem_addr 0, mem_wdata 0, resp_valid 0, resp_exc 0, resp_exc_code 0, resp_data/resp_badaddr/resp_pc 0.
  - req_ready=1 from the first cycle after reset deasserts.
- Latency with acceptance at edge T:
  - Store: mem_en in cycle T+1, resp_valid in T+2.
  - Load: mem_en in T+1, mem_rdata sampled at the end of T+2, resp_valid with resp_data in T+3.
  - Fault: resp_valid in T+2; mem_en is never asserted.
- Next acceptance is possible at the edge ending the RESP cycle+1, i.e. when the state has returned to IDLE. Peak rate is one store per 3 cycles or one load per 4 cycles.
- All mem_* and resp_* outputs are driven from registers; they are not combinational from req_*.
- Outside the strobe cycle, mem_en=0 and mem_we=0; mem_addr/mem_be/mem_wdata hold their last values.
- Reset asserted in any state aborts the operation:
  - No further mem_en and no resp_valid for the aborted request.
  - If reset coincides with the ISSUE cycle, the strobe already driven in that cycle stands; nothing follows it.
- req_valid while req_ready=0 is ignored and not queued.
- EA wrap: base 0xFFFF_FFFC with offset +8 gives EA 0x4, a legal access.

## Test plan
- SW base 0x100, offset 0x8, wdata 0xDEADBEEF → mem_en/mem_we in T+1, mem_addr 0x042, be 1111, wdata 0xDEADBEEF; resp_valid T+2, resp_exc 0.
- SB EA 0x103, wdata 0x000000A5 → be 1000, mem_wdata 0xA5A5A5A5; then LB EA 0x103 with mem_rdata 0xA5000000 → resp_data 0xFFFFFFA5; LBU → 0x000000A5.
- SH EA 0x102, wdata 0x1234_8001 → be 1100, wdata 0x80018001; LH EA 0x102 with rdata 0x8001_0000 → 0xFFFF8001; LHU → 0x00008001.
- LW EA 0x106 → no mem_en, resp_valid T+2, exc_code 1, badaddr 0x106; SW EA 0x3000 → exc_code 2; LH EA 0x3001 → exc_code 1.
- Back-to-back req_valid held high with SW, LW → second accepted only after the first resp_valid; exactly one mem_en per request; req_valid pulses while busy are dropped.
- Reset asserted in the CAPTURE cycle of a load → no resp_valid; all outputs return to reset values; a new LW issued afterwards completes normally.
